alu_share_arbiter: RTL and testbench

- Shares one external ALU (opcode/in_A/in_B out, res/status in) between two requesters.
- Round-robin arbitration with a req/gnt/done handshake.
- Drives the ALU operands and holds them stable for a fixed latency.
- Captures res/status and returns them to the granted requester with a one-cycle done pulse.
- Sits between the compare/count sequencers and the shared ALU.

---
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 tb/tb_alu_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one fixed-latency external ALU between two requesters.
// It holds the ALU operands for ALU_LAT cycles, then returns res/status with a one-cycle done pulse.
module alu_share_arbiter #(
  parameter int unsigned W       = 2,
  parameter int unsigned OPW     = 5,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic [OPW-1:0] op0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic           req1,
  input  logic [OPW-1:0] op1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [W-1:0]   rdata,
  output logic           rstatus,
  output logic [OPW-1:0] opcode,
  output logic [W-1:0]   in_A,
  output logic [W-1:0]   in_B,
  input  logic [W-1:0]   res,
  input  logic           status
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          ptr;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          sel_c;

  // Winner if arbitration happens this cycle: a lone request wins, a tie goes to the pointer.
  always_comb begin
    sel_c = 1'b0;
    if (req0 && req1) begin
      sel_c = ptr;
    end else if (req1) begin
      sel_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata   <= '0;
      rstatus <= 1'b0;
      opcode  <= '0;
      in_A    <= '0;
      in_B    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 || req1) begin
            owner  <= sel_c;
            opcode <= sel_c ? op1 : op0;
            in_A   <= sel_c ? a1 : a0;
            in_B   <= sel_c ? b1 : b0;
            gnt0   <= ~sel_c;
            gnt1   <= sel_c;
            cnt    <= CW'(ALU_LAT - 1);
            state  <= BUSY;
          end
        end
        // Operands stay frozen; capture the ALU result once the latency has elapsed.
        BUSY: begin
          if (cnt == '0) begin
            rdata   <= res;
            rstatus <= status;
            done0   <= ~owner;
            done1   <= owner;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            ptr     <= ~owner;
            state   <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter against a one-register ALU model (add/sub/and/or).
module tb_alu_share_arbiter;

  localparam int unsigned W   = 2;
  localparam int unsigned OPW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0, req1;
  logic [OPW-1:0] op0, op1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, done0, done1;
  logic [W-1:0]   rdata;
  logic           rstatus;
  logic [OPW-1:0] opcode;
  logic [W-1:0]   in_A, in_B;
  logic [W-1:0]   res;
  logic           status;

  int vectors     = 0;
  int miscompares = 0;

  alu_share_arbiter #(.W(W), .OPW(OPW), .ALU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .rstatus(rstatus),
    .opcode(opcode), .in_A(in_A), .in_B(in_B),
    .res(res), .status(status)
  );

  always #5 clk = ~clk;

  // ALU model: 0 add (carry), 1 sub (borrow), 2 and, 3 or; one register stage of latency.
  logic [W:0] alu_c;
  always_comb begin
    alu_c = '0;
    case (opcode)
      5'd0:    alu_c = {1'b0, in_A} + {1'b0, in_B};
      5'd1:    alu_c = {1'b0, in_A} - {1'b0, in_B};
      5'd2:    alu_c = {1'b0, in_A & in_B};
      5'd3:    alu_c = {1'b0, in_A | in_B};
      default: alu_c = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    res    <= alu_c[W-1:0];
    status <= alu_c[W];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=0000", {gnt0, gnt1, done0, done1});
    end
    vectors++;
    if ({rdata, rstatus, opcode, in_A, in_B} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got rdata=%0d rstatus=%0d opcode=%0d in_A=%0d in_B=%0d exp all 0",
               rdata, rstatus, opcode, in_A, in_B);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; op0 = 5'b00010; a0 = 2'b11; b0 = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (k < 2) begin
        if ({gnt0, gnt1, done0, done1} !== 4'b1000 || opcode !== 5'd2 || in_A !== 2'd3 || in_B !== 2'd2) begin
          miscompares++;
          $display("FAIL single_busy k=%0d got flags=%b op=%0d A=%0d B=%0d exp flags=1000 op=2 A=3 B=2",
                   k, {gnt0, gnt1, done0, done1}, opcode, in_A, in_B);
        end
      end else if (k == 2) begin
        if ({gnt0, gnt1, done0, done1} !== 4'b0010 || rdata !== 2'b10 || rstatus !== 1'b0) begin
          miscompares++;
          $display("FAIL single_done got flags=%b rdata=%b rstatus=%b exp flags=0010 rdata=10 rstatus=0",
                   {gnt0, gnt1, done0, done1}, rdata, rstatus);
        end
        req0 = 1'b0;
      end else begin
        if ({gnt0, gnt1, done0, done1} !== 4'b0000 || rdata !== 2'b10) begin
          miscompares++;
          $display("FAIL single_after got flags=%b rdata=%b exp flags=0000 rdata=10",
                   {gnt0, gnt1, done0, done1}, rdata);
        end
      end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_flags;
    logic       own;
    do_reset();
    req0 = 1'b1; op0 = 5'd2; a0 = 2'd3; b0 = 2'd1;   // and -> 01
    req1 = 1'b1; op1 = 5'd3; a1 = 2'd2; b1 = 2'd1;   // or  -> 11
    for (int k = 0; k < 16; k++) begin
      tick();
      own = ((k / 4) % 2) == 1;
      case (k % 4)
        0, 1:    exp_flags = own ? 4'b0100 : 4'b1000;
        2:       exp_flags = own ? 4'b0001 : 4'b0010;
        default: exp_flags = 4'b0000;
      endcase
      vectors++;
      if ({gnt0, gnt1, done0, done1} !== exp_flags) begin
        miscompares++;
        $display("FAIL alternate_flags k=%0d got=%b exp=%b", k, {gnt0, gnt1, done0, done1}, exp_flags);
      end
      if (k % 4 == 2) begin
        vectors++;
        if (rdata !== (own ? 2'b11 : 2'b01)) begin
          miscompares++;
          $display("FAIL alternate_rdata k=%0d got=%b exp=%b", k, rdata, own ? 2'b11 : 2'b01);
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_req1_sub();
    logic [3:0] exp_flags;
    do_reset();
    req1 = 1'b1; op1 = 5'd1; a1 = 2'b01; b1 = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      case (k)
        0, 1:    exp_flags = 4'b0100;
        2:       exp_flags = 4'b0001;
        default: exp_flags = 4'b0000;
      endcase
      vectors++;
      if ({gnt0, gnt1, done0, done1} !== exp_flags) begin
        miscompares++;
        $display("FAIL sub_flags k=%0d got=%b exp=%b", k, {gnt0, gnt1, done0, done1}, exp_flags);
      end
      if (k == 2) begin
        vectors++;
        if (rdata !== 2'b11 || rstatus !== 1'b1) begin
          miscompares++;
          $display("FAIL sub_result got rdata=%b rstatus=%b exp rdata=11 rstatus=1", rdata, rstatus);
        end
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_operand_change();
    do_reset();
    req0 = 1'b1; op0 = 5'd2; a0 = 2'd3; b0 = 2'd2;
    tick();
    op0 = 5'd3; a0 = 2'd1; b0 = 2'd0;
    for (int k = 1; k < 3; k++) begin
      tick();
      vectors++;
      if (opcode !== 5'd2 || in_A !== 2'd3 || in_B !== 2'd2) begin
        miscompares++;
        $display("FAIL change_hold k=%0d got op=%0d A=%0d B=%0d exp op=2 A=3 B=2", k, opcode, in_A, in_B);
      end
    end
    vectors++;
    if (done0 !== 1'b1 || rdata !== 2'b10) begin
      miscompares++;
      $display("FAIL change_result got done0=%b rdata=%b exp done0=1 rdata=10", done0, rdata);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (opcode !== 5'd2 || in_A !== 2'd3 || in_B !== 2'd2 || gnt0 !== 1'b0) begin
      miscompares++;
      $display("FAIL change_idle_hold got op=%0d A=%0d B=%0d gnt0=%b exp op=2 A=3 B=2 gnt0=0",
               opcode, in_A, in_B, gnt0);
    end
    req0 = 1'b1;
    tick();
    vectors++;
    if (gnt0 !== 1'b1 || opcode !== 5'd3 || in_A !== 2'd1 || in_B !== 2'd0) begin
      miscompares++;
      $display("FAIL change_regrant got gnt0=%b op=%0d A=%0d B=%0d exp gnt0=1 op=3 A=1 B=0",
               gnt0, opcode, in_A, in_B);
    end
    req0 = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_hold_req0();
    logic [3:0] exp_flags;
    do_reset();
    req0 = 1'b1; op0 = 5'd0; a0 = 2'd1; b0 = 2'd1;   // add -> 10, carry 0
    for (int k = 0; k < 12; k++) begin
      tick();
      case (k % 4)
        0, 1:    exp_flags = 4'b1000;
        2:       exp_flags = 4'b0010;
        default: exp_flags = 4'b0000;
      endcase
      vectors++;
      if ({gnt0, gnt1, done0, done1} !== exp_flags) begin
        miscompares++;
        $display("FAIL hold_flags k=%0d got=%b exp=%b", k, {gnt0, gnt1, done0, done1}, exp_flags);
      end
      if (k % 4 == 2) begin
        vectors++;
        if (rdata !== 2'b10 || rstatus !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_result k=%0d got rdata=%b rstatus=%b exp rdata=10 rstatus=0", k, rdata, rstatus);
        end
      end
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    // First complete one op for requester 0 so the pointer moves to 1.
    req0 = 1'b1; op0 = 5'b00010; a0 = 2'b11; b0 = 2'b10;
    tick(); tick(); tick();
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    tick();
    vectors++;
    if ({gnt0, gnt1, done0, done1} !== 4'b1000) begin
      miscompares++;
      $display("FAIL midbusy_grant got=%b exp=1000", {gnt0, gnt1, done0, done1});
    end
    rst_n = 1'b0;
    req0 = 1'b0;
    tick();
    vectors++;
    if ({gnt0, gnt1, done0, done1} !== 4'b0000 || {rdata, rstatus, opcode, in_A, in_B} !== '0) begin
      miscompares++;
      $display("FAIL midbusy_reset got flags=%b rdata=%0d rstatus=%0d op=%0d A=%0d B=%0d exp all 0",
               {gnt0, gnt1, done0, done1}, rdata, rstatus, opcode, in_A, in_B);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
        miscompares++;
        $display("FAIL midbusy_no_done k=%0d got=%b exp=0000", k, {gnt0, gnt1, done0, done1});
      end
    end
    req0 = 1'b1; req1 = 1'b1; op1 = 5'd3; a1 = 2'd1; b1 = 2'd2;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL midbusy_pointer got gnt0/gnt1=%b exp=10", {gnt0, gnt1});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_req1_sub();
    test_operand_change();
    test_hold_req0();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
